fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer for the single-stage RV32 core. It owns the program counter register and the next-PC selection. It runs a single-outstanding request/grant/response handshake to instruction memory and holds each fetched instruction until the execute stage consumes it. It also detects misaligned control-flow targets and counts retired instructions.

## Interface
Parameters:
- RESET_VEC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous and active-high.
- halt_req  in  1  when high, no new fetch is issued (state IDLE).
- imem_req  out  1  fetch request; high only in FETCH.
- imem_addr  out  32  fetch address, equal to pc_q.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid this cycle.
- imem_rdata  in  32  instruction word.
- inst_valid  out  1  held instruction available; high only in HOLD.
- inst  out  32  held instruction word.
- inst_pc  out  32  PC of the held instruction (pc_q).
- inst_ready  in  1  execute consumes the instruction this cycle.
- pc_sel  in  2  next-PC select, sampled on consume: 00 = pc+4, 01 = pc+imm, 11 = alu_out & ~1, 10 = treated as 00.
- imm  in  32  branch/jal offset.
- alu_out  in  32  jalr target before bit-0 clear.
- fault  out  1  sticky misaligned-target flag.
- fault_addr  out  32  offending target address.
- retire_cnt  out  32  consumed-instruction count, wraps mod 2^32.

## Operation
- States: IDLE, FETCH, WAIT, HOLD, FAULT.
- Reset:
  - state = IDLE, pc_q = RESET_VEC, inst = 0, retire_cnt = 0, fault = 0, fault_addr = 0.
  - All outputs derived from state are low.
- IDLE:
  - Go to FETCH when halt_req = 0; otherwise stay.
- FETCH:
  - imem_req = 1, imem_addr = pc_q.
  - imem_gnt = 0: stay; address stays stable.
  - imem_gnt = 1, imem_rvalid = 0: go to WAIT.
  - imem_gnt = 1, imem_rvalid = 1 (zero-wait memory): latch imem_rdata into inst and go directly to HOLD.
  - imem_rvalid without imem_gnt: ignored (stale response).
- WAIT:
  - imem_rvalid = 1: latch imem_rdata into inst and go to HOLD; otherwise stay.
  - imem_gnt is ignored in this state.
- HOLD:
  - inst_valid = 1. inst and inst_pc stay stable until consumed.
  - On inst_ready = 1, compute target from pc_sel.
  - Arithmetic is 32-bit unsigned and wraps; no carry is kept.
  - If target[1:0] != 0: go to FAULT, set fault = 1, fault_addr = target. pc_q and retire_cnt are unchanged.
  - Otherwise: pc_q <= target and retire_cnt increments. Go to IDLE if halt_req = 1, else to FETCH.
- FAULT:
  - Terminal state; all handshake outputs are low. Only rst exits it.
- halt_req is sampled only in IDLE and at consume; it does not abort an in-flight fetch.

## Timing
- Zero-wait memory:
  - Request issued in cycle N; inst_valid is high in N+1.
  - Consumed in N+1 means the next imem_req is in N+2.
  - Peak throughput: 1 instruction per 2 cycles.
- Out of reset (rst low at cycle R, halt_req = 0): IDLE in R, first imem_req in R+1.
- Memory with k wait cycles (rvalid k cycles after gnt): inst_valid rises the cycle after rvalid.
- retire_cnt, pc_q and fault update on the clock edge that ends the consume cycle.
- rst has priority over every event, including a simultaneous gnt, rvalid or consume.
  - A response still outstanding at reset is dropped. The memory must not deliver it later together with a new gnt.

## Test plan
- Reset / boot: RESET_VEC = 32'h0000_0100, halt_req = 0, zero-wait memory, inst_ready = 1, pc_sel = 00 -> imem_addr sequence 0x100, 0x104, 0x108 on req cycles 1, 3, 5 after reset; retire_cnt = 3 after the third consume.
- Wait states: gnt held low 2 cycles, then rvalid 3 cycles after gnt -> imem_addr stable through the stall; inst_valid rises the cycle after rvalid; inst = rdata (e.g. 32'h0000_0013).
- Branch / jalr: pc_q = 0x200 with pc_sel = 01, imm = 32'hFFFF_FFF0 -> next addr 0x1F0; then pc_sel = 11, alu_out = 0x305 -> next addr 0x304.
- Misaligned target: pc_sel = 01, imm = 0x6 from pc 0x0 -> fault = 1, fault_addr = 0x6, imem_req stays low, retire_cnt unchanged; rst clears fault.
- Halt and stall: halt_req = 1 at consume -> IDLE with no req; release -> req next cycle. inst_ready held low 4 cycles -> inst and inst_pc stable, no req issued.
- Reset mid-fetch: rst in WAIT, then a stale rvalid in FETCH without gnt -> ignored; fetch restarts at RESET_VEC; wrap check: pc 0xFFFF_FFFC with pc_sel = 00 -> 0x0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs a single-outstanding
// req/gnt/rvalid fetch, holds the instruction until consumed, flags misaligned targets.
module fetch_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt_req,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] imm,
  input  logic [31:0] alu_out,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [31:0] retire_cnt
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, HOLD, FAULT} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] retire_q;
  logic [31:0] fault_addr_q;
  logic        fault_q;
  logic        req_q;
  logic        valid_q;
  logic [31:0] target_d;
  logic        misaligned_d;

  always_comb begin
    target_d = pc_q + 32'd4;
    unique case (pc_sel)
      2'b01:   target_d = pc_q + imm;
      2'b11:   target_d = alu_out & ~32'd1;
      default: target_d = pc_q + 32'd4;
    endcase
    misaligned_d = |target_d[1:0];
  end

  // req/valid are registered alongside the state so they track it exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_VEC;
      inst_q       <= '0;
      retire_q     <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
      req_q        <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!halt_req) begin
            state_q <= FETCH;
            req_q   <= 1'b1;
          end
        end
        FETCH: begin
          if (imem_gnt) begin
            req_q <= 1'b0;
            if (imem_rvalid) begin
              inst_q  <= imem_rdata;
              valid_q <= 1'b1;
              state_q <= HOLD;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            inst_q  <= imem_rdata;
            valid_q <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (inst_ready) begin
            valid_q <= 1'b0;
            if (misaligned_d) begin
              fault_q      <= 1'b1;
              fault_addr_q <= target_d;
              state_q      <= FAULT;
            end else begin
              pc_q     <= target_d;
              retire_q <= retire_q + 32'd1;
              if (halt_req) begin
                state_q <= IDLE;
              end else begin
                state_q <= FETCH;
                req_q   <= 1'b1;
              end
            end
          end
        end
        FAULT: begin
          state_q <= FAULT;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign inst_valid = valid_q;
  assign inst       = inst_q;
  assign inst_pc    = pc_q;
  assign fault      = fault_q;
  assign fault_addr = fault_addr_q;
  assign retire_cnt = retire_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: vector table of next-PC selections plus hand sequences
// for wait states, stalls, halt, fault and reset during an outstanding fetch.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt_req;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [1:0]  pc_sel;
  logic [31:0] imm;
  logic [31:0] alu_out;
  logic        fault;
  logic [31:0] fault_addr;
  logic [31:0] retire_cnt;

  fetch_ctrl #(.RESET_VEC(32'h0000_0100)) dut (
    .clk(clk), .rst(rst), .halt_req(halt_req),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .pc_sel(pc_sel), .imm(imm), .alu_out(alu_out),
    .fault(fault), .fault_addr(fault_addr), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } sb_t;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] imm;
    logic [31:0] alu;
    logic [31:0] exp_next;
    logic        exp_fault;
  } vec_t;

  sb_t         sb[$];
  vec_t        vecs[9];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_ret;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expects FETCH on entry; leaves the DUT in HOLD with the response checked.
  task automatic fetch(input int gnt_dly, input int rv_dly, input logic [31:0] data);
    sb_t e;
    chk("req_in_fetch", 32'(imem_req), 32'd1);
    chk("addr_in_fetch", imem_addr, exp_pc);
    for (int i = 0; i < gnt_dly; i++) begin
      imem_gnt = 1'b0;
      tick();
      chk("req_stall", 32'(imem_req), 32'd1);
      chk("addr_stable", imem_addr, exp_pc);
    end
    imem_gnt    = 1'b1;
    imem_rvalid = (rv_dly == 0);
    imem_rdata  = (rv_dly == 0) ? data : 32'hDEAD_BEEF;
    sb.push_back('{addr: exp_pc, data: data});
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    if (rv_dly > 0) begin
      for (int i = 0; i < rv_dly - 1; i++) begin
        chk("wait_no_valid", 32'(inst_valid), 32'd0);
        chk("wait_no_req", 32'(imem_req), 32'd0);
        tick();
      end
      chk("wait_no_valid", 32'(inst_valid), 32'd0);
      imem_rvalid = 1'b1;
      imem_rdata  = data;
      tick();
      imem_rvalid = 1'b0;
    end
    imem_rdata = 32'hDEAD_BEEF;
    chk("inst_valid_hold", 32'(inst_valid), 32'd1);
    chk("req_low_hold", 32'(imem_req), 32'd0);
    if (sb.size() == 0) begin
      fails++;
      tests++;
      $display("FAIL scoreboard_empty: got response expected none");
    end else begin
      e = sb.pop_front();
      chk("inst_data", inst, e.data);
      chk("inst_pc", inst_pc, e.addr);
    end
  endtask

  task automatic consume(input logic [1:0] sel, input logic [31:0] im,
                         input logic [31:0] alu, input logic halt);
    inst_ready = 1'b1;
    pc_sel     = sel;
    imm        = im;
    alu_out    = alu;
    halt_req   = halt;
    tick();
    inst_ready = 1'b0;
    pc_sel     = 2'b00;
    imm        = '0;
    alu_out    = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'b00, 32'h0,         32'h0,         32'h0000_0104, 1'b0};
    vecs[1] = '{2'b00, 32'h0,         32'h0,         32'h0000_0108, 1'b0};
    vecs[2] = '{2'b00, 32'h0,         32'h0,         32'h0000_010C, 1'b0};
    vecs[3] = '{2'b01, 32'h0000_00F4, 32'h0,         32'h0000_0200, 1'b0};
    vecs[4] = '{2'b01, 32'hFFFF_FFF0, 32'h0,         32'h0000_01F0, 1'b0};
    vecs[5] = '{2'b11, 32'h0,         32'h0000_0305, 32'h0000_0304, 1'b0};
    vecs[6] = '{2'b10, 32'h1234_5677, 32'h0000_0999, 32'h0000_0308, 1'b0};
    vecs[7] = '{2'b11, 32'h0,         32'hFFFF_FFFD, 32'hFFFF_FFFC, 1'b0};
    vecs[8] = '{2'b00, 32'h0,         32'h0,         32'h0000_0000, 1'b0};

    rst = 1'b1; halt_req = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = '0; inst_ready = 1'b0; pc_sel = 2'b00; imm = '0; alu_out = '0;
    tick();
    tick();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_retire", retire_cnt, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_fault_addr", fault_addr, 32'd0);
    chk("rst_addr", imem_addr, 32'h0000_0100);
    rst = 1'b0;
    exp_pc = 32'h0000_0100;
    exp_ret = '0;
    chk("idle_after_rst", 32'(imem_req), 32'd0);
    tick();

    // Zero-wait fetch/consume chain through the vector table, ending on a wrap to 0.
    for (int i = 0; i < 9; i++) begin
      fetch(0, 0, exp_pc ^ 32'h1357_0013);
      consume(vecs[i].sel, vecs[i].imm, vecs[i].alu, 1'b0);
      exp_pc = vecs[i].exp_next;
      exp_ret = exp_ret + 32'd1;
      chk("next_req", 32'(imem_req), 32'd1);
      chk("next_addr", imem_addr, exp_pc);
      chk("retire", retire_cnt, exp_ret);
      chk("no_fault", 32'(fault), 32'd0);
    end

    // Misaligned branch from pc 0: pc+6.
    fetch(0, 0, 32'h0000_0063);
    consume(2'b01, 32'h0000_0006, 32'h0, 1'b0);
    chk("fault_set", 32'(fault), 32'd1);
    chk("fault_addr", fault_addr, 32'h0000_0006);
    chk("fault_pc_kept", imem_addr, 32'h0000_0000);
    chk("fault_retire_kept", retire_cnt, exp_ret);
    for (int i = 0; i < 3; i++) begin
      imem_gnt = 1'b1; imem_rvalid = 1'b1; inst_ready = 1'b1;
      chk("fault_no_req", 32'(imem_req), 32'd0);
      chk("fault_no_valid", 32'(inst_valid), 32'd0);
      tick();
    end
    imem_gnt = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0;
    chk("fault_sticky", 32'(fault), 32'd1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_pc = 32'h0000_0100;
    exp_ret = '0;
    chk("rst_clears_fault", 32'(fault), 32'd0);
    chk("rst_clears_fault_addr", fault_addr, 32'd0);
    chk("rst_clears_retire", retire_cnt, 32'd0);
    chk("rst_pc", imem_addr, 32'h0000_0100);
    tick();

    // Wait states, then a 4-cycle execute stall, then halt at consume.
    fetch(2, 3, 32'h0000_0013);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_valid", 32'(inst_valid), 32'd1);
      chk("stall_inst", inst, 32'h0000_0013);
      chk("stall_inst_pc", inst_pc, 32'h0000_0100);
      chk("stall_no_req", 32'(imem_req), 32'd0);
    end
    consume(2'b00, 32'h0, 32'h0, 1'b1);
    exp_pc = 32'h0000_0104;
    exp_ret = 32'd1;
    chk("halt_no_req", 32'(imem_req), 32'd0);
    chk("halt_no_valid", 32'(inst_valid), 32'd0);
    chk("halt_retire", retire_cnt, exp_ret);
    tick();
    chk("halt_hold_no_req", 32'(imem_req), 32'd0);
    halt_req = 1'b0;
    tick();
    chk("release_req", 32'(imem_req), 32'd1);
    chk("release_addr", imem_addr, exp_pc);

    // Reset while the response is outstanding, coinciding with rvalid and ready.
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    chk("wait_state_req", 32'(imem_req), 32'd0);
    rst = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hFFFF_FFFF; inst_ready = 1'b1;
    tick();
    rst = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0;
    exp_pc = 32'h0000_0100;
    exp_ret = '0;
    chk("midrst_valid", 32'(inst_valid), 32'd0);
    chk("midrst_inst", inst, 32'd0);
    chk("midrst_addr", imem_addr, exp_pc);
    chk("midrst_retire", retire_cnt, 32'd0);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h0BAD_0BAD;
    tick();
    imem_rvalid = 1'b0;
    chk("stale_ignored_req", 32'(imem_req), 32'd1);
    chk("stale_ignored_valid", 32'(inst_valid), 32'd0);
    chk("stale_ignored_addr", imem_addr, exp_pc);
    fetch(1, 1, 32'h0010_0093);
    consume(2'b00, 32'h0, 32'h0, 1'b0);
    chk("restart_retire", retire_cnt, 32'd1);
    chk("restart_next_addr", imem_addr, 32'h0000_0104);

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
